// File: rtl/switch_out_sched_if.sv
// Handshake bundle between the switch port logic and the output scheduler.
interface switch_out_sched_if;
  logic [3:0]  in_req;
  logic [7:0]  in_dest;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  out_ready;
  logic [3:0]  port_en;
  logic [3:0]  in_grant;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [11:0] xbar_sel;
  logic [3:0]  timeout_err;

  // Port logic side: drives requests/beats, observes scheduling decisions.
  modport master (
    output in_req, in_dest, in_valid, in_last, out_ready, port_en,
    input  in_grant, in_ready, out_valid, xbar_sel, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  in_req, in_dest, in_valid, in_last, out_ready, port_en,
    output in_grant, in_ready, out_valid, xbar_sel, timeout_err
  );
endinterface

// File: rtl/switch_out_sched.sv
// Output-port scheduler for the 4-port switch: per-output packet-granular round-robin
// arbitration, crossbar select generation and a stall watchdog that force-releases outputs.
module switch_out_sched #(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  switch_out_sched_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                            state_q [PORTS];
  state_e                            state_d [PORTS];
  logic [1:0]                        owner_q [PORTS];
  logic [1:0]                        owner_d [PORTS];
  logic [1:0]                        rr_q    [PORTS];
  logic [1:0]                        rr_d    [PORTS];
  logic [CntW-1:0]                   cnt_q   [PORTS];
  logic [CntW-1:0]                   cnt_d   [PORTS];
  logic [PORTS-1:0]                  err_q;
  logic [PORTS-1:0]                  err_d;
  logic [2:0]                        win     [PORTS];
  logic [PORTS-1:0][PORTS-1:0]       cand;
  logic [PORTS-1:0]                  grant;
  logic [PORTS-1:0]                  ready;
  logic [PORTS-1:0]                  valid;
  logic [PORTS-1:0]                  xfer;
  logic [3*PORTS-1:0]                xsel;

  // Round-robin pick: {found, index} of the first set bit at ptr, ptr+1, ... mod 4.
  // Scanning offsets downwards lets the smallest offset overwrite the others.
  function automatic logic [2:0] pick(input logic [3:0] c, input logic [1:0] ptr);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (c[idx]) pick = {1'b1, idx};
    end
  endfunction

  // Crossbar steering and beat gating, all derived from registered ownership.
  always_comb begin
    grant = '0;
    ready = '0;
    valid = '0;
    xsel  = '0;
    for (int j = 0; j < PORTS; j++) begin
      if (state_q[j] == StBusy) begin
        grant[owner_q[j]]  = 1'b1;
        ready[owner_q[j]]  = bus.out_ready[j];
        valid[j]           = bus.in_valid[owner_q[j]];
        xsel[3*j +: 3]     = {1'b1, owner_q[j]};
      end
    end
    xfer = valid & bus.out_ready;
  end

  // Candidate matrix and round-robin winner per output.
  always_comb begin
    cand = '0;
    for (int j = 0; j < PORTS; j++) begin
      for (int i = 0; i < PORTS; i++) begin
        cand[j][i] = bus.in_req[i] & (bus.in_dest[2*i +: 2] == 2'(j)) & ~grant[i];
      end
      win[j] = pick(cand[j], rr_q[j]);
    end
  end

  // Per-output FSM next state: grant in idle, release on last beat or on stall timeout.
  always_comb begin
    err_d = '0;
    for (int j = 0; j < PORTS; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
      rr_d[j]    = rr_q[j];
      cnt_d[j]   = cnt_q[j];
      unique case (state_q[j])
        StIdle: begin
          if (bus.port_en[j] && win[j][2]) begin
            state_d[j] = StBusy;
            owner_d[j] = win[j][1:0];
            cnt_d[j]   = '0;
          end
        end
        StBusy: begin
          if (xfer[j]) begin
            // A completing transfer wins over a simultaneous watchdog expiry.
            if (bus.in_last[owner_q[j]]) begin
              state_d[j] = StIdle;
              rr_d[j]    = owner_q[j] + 2'd1;
            end else begin
              cnt_d[j] = '0;
            end
          end else if (cnt_q[j] == CntW'(TIMEOUT - 1)) begin
            state_d[j] = StIdle;
            rr_d[j]    = owner_q[j] + 2'd1;
            err_d[j]   = 1'b1;
          end else begin
            cnt_d[j] = cnt_q[j] + 1'b1;
          end
        end
        default: state_d[j] = StIdle;
      endcase
    end
  end

  // State registers; reset abandons any packet in flight without an error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < PORTS; j++) begin
        state_q[j] <= StIdle;
        owner_q[j] <= '0;
        rr_q[j]    <= '0;
        cnt_q[j]   <= '0;
      end
      err_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_grant    = grant;
  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid;
  assign bus.xbar_sel    = xsel;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_switch_out_sched.sv
// Randomized bench for switch_out_sched: packet sources plus a scheduling reference model
// push expected outputs into a queue; a negedge monitor pops and compares.
module tb_switch_out_sched;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_out_sched_if bus();

  switch_out_sched #(.PORTS(4), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] req, valid, last, ready, pen;
  logic [7:0] dest;

  assign bus.in_req    = req;
  assign bus.in_dest   = dest;
  assign bus.in_valid  = valid;
  assign bus.in_last   = last;
  assign bus.out_ready = ready;
  assign bus.port_en   = pen;

  typedef struct packed {
    logic [3:0]  grant;
    logic [3:0]  rdy;
    logic [3:0]  vld;
    logic [3:0]  err;
    logic [11:0] xsel;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: owner per output (-1 = free), round-robin pointer, stall count.
  int own[4];
  int rr[4];
  int stall[4];
  bit err[4];
  // Packet sources.
  bit has_pkt[4];
  int pdest[4];
  int rem[4];

  function automatic int owner_of_input(int i);
    for (int j = 0; j < 4; j++) if (own[j] == i) return j;
    return -1;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    for (int j = 0; j < 4; j++) begin
      if (own[j] >= 0) begin
        e.grant[own[j]]   = 1'b1;
        e.rdy[own[j]]     = ready[j];
        e.vld[j]          = valid[own[j]];
        e.xsel[3*j +: 3]  = {1'b1, 2'(own[j])};
      end
      e.err[j] = err[j];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 4; j++) begin
      own[j] = -1; rr[j] = 0; stall[j] = 0; err[j] = 1'b0;
    end
    // Sources restart any abandoned packet from its first beat.
    for (int i = 0; i < 4; i++) if (has_pkt[i]) rem[i] = $urandom_range(1, 4);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    int nown[4], nrr[4], nst[4];
    bit nerr[4];
    int i, o;
    if (rst) return;
    for (int j = 0; j < 4; j++) begin
      nown[j] = own[j]; nrr[j] = rr[j]; nst[j] = stall[j]; nerr[j] = 1'b0;
      if (own[j] < 0) begin
        if (pen[j]) begin
          for (int k = 0; k < 4; k++) begin
            i = (rr[j] + k) % 4;
            if (req[i] && dest[2*i +: 2] == 2'(j) && owner_of_input(i) < 0) begin
              nown[j] = i;
              nst[j]  = 0;
              break;
            end
          end
        end
      end else begin
        o = own[j];
        if (valid[o] && ready[j]) begin
          rem[o]--;
          if (last[o]) begin
            nown[j] = -1; nrr[j] = (o + 1) % 4; has_pkt[o] = 1'b0;
          end else begin
            nst[j] = 0;
          end
        end else if (stall[j] + 1 == TIMEOUT) begin
          nown[j] = -1; nrr[j] = (o + 1) % 4; nerr[j] = 1'b1; has_pkt[o] = 1'b0;
        end else begin
          nst[j] = stall[j] + 1;
        end
      end
    end
    for (int j = 0; j < 4; j++) begin
      own[j] = nown[j]; rr[j] = nrr[j]; stall[j] = nst[j]; err[j] = nerr[j];
    end
  endtask

  task automatic drive(int pv, int pr, int pe);
    for (int i = 0; i < 4; i++) begin
      if (!has_pkt[i] && $urandom_range(99) < 35) begin
        has_pkt[i] = 1'b1;
        pdest[i]   = $urandom_range(3);
        rem[i]     = $urandom_range(1, 4);
      end
      if (owner_of_input(i) < 0) begin
        req[i]           = has_pkt[i];
        dest[2*i +: 2]   = has_pkt[i] ? 2'(pdest[i]) : 2'($urandom_range(3));
        valid[i]         = 1'($urandom_range(1));
        last[i]          = 1'($urandom_range(1));
      end else begin
        // Destination and request are don't-care while owned.
        req[i]           = 1'($urandom_range(1));
        dest[2*i +: 2]   = 2'($urandom_range(3));
        valid[i]         = ($urandom_range(99) < pv);
        last[i]          = (rem[i] == 1);
      end
    end
    for (int j = 0; j < 4; j++) begin
      ready[j] = ($urandom_range(99) < pr);
      pen[j]   = ($urandom_range(99) < pe);
    end
  endtask

  task automatic chk(string name, logic [11:0] got, logic [11:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, expv);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("in_grant",    12'(bus.in_grant),    12'(e.grant));
        chk("in_ready",    12'(bus.in_ready),    12'(e.rdy));
        chk("out_valid",   12'(bus.out_valid),   12'(e.vld));
        chk("timeout_err", 12'(bus.timeout_err), 12'(e.err));
        chk("xbar_sel",    bus.xbar_sel,         e.xsel);
      end
    end
  end

  // Stimulus: four traffic phases, each opening with a reset (mid-traffic after the first).
  initial begin
    int pv_tab[4] = '{90, 60, 80, 95};
    int pr_tab[4] = '{90, 8, 70, 3};
    int pe_tab[4] = '{100, 100, 50, 100};
    for (int i = 0; i < 4; i++) begin
      has_pkt[i] = 1'b0; pdest[i] = 0; rem[i] = 0;
    end
    model_reset();
    req = '0; valid = '0; last = '0; ready = '0; pen = '0; dest = '0;
    @(posedge clk);
    #1;
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 400; c++) begin
        rst = (c < 3);
        if (rst) model_reset();
        drive(pv_tab[ph], pr_tab[ph], pe_tab[ph]);
        exp_q.push_back(expect_now());
        model_step();
        cyc++;
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("drain", 12'(exp_q.size()), 12'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
